// File: rtl/branch_predictor.sv
// Dynamic branch predictor: combinational IF-stage lookup over registered counter/BTB
// tables, trained by resolved branches from EX/MEM. Bimodal or gshare indexing.
module branch_predictor #(
    parameter int unsigned PC_W  = 32,
    parameter int unsigned IDX_W = 6,
    parameter int unsigned CTR_W = 2,
    parameter int unsigned GHR_W = 6,
    parameter int unsigned TAG_W = 8,
    parameter int unsigned MODE  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [PC_W-1:0]  if_pc,
    output logic             pred_taken,
    output logic [PC_W-1:0]  pred_target,
    output logic [GHR_W-1:0] pred_ghr,
    input  logic             upd_valid,
    input  logic [PC_W-1:0]  upd_pc,
    input  logic [GHR_W-1:0] upd_ghr,
    input  logic             upd_taken,
    input  logic [PC_W-1:0]  upd_target,
    input  logic             upd_mispredict,
    output logic [31:0]      branch_cnt,
    output logic [31:0]      mispredict_cnt
);

    localparam int unsigned      ENTRIES = 1 << IDX_W;
    localparam logic [CTR_W-1:0] CTR_RST = CTR_W'((1 << (CTR_W - 1)) - 1);
    localparam logic [CTR_W-1:0] CTR_MAX = '1;
    localparam logic [31:0]      CNT_MAX = '1;

    logic [CTR_W-1:0] r_ctr       [ENTRIES];
    logic             r_btb_valid [ENTRIES];
    logic [TAG_W-1:0] r_btb_tag   [ENTRIES];
    logic [PC_W-1:0]  r_btb_tgt   [ENTRIES];
    logic [GHR_W-1:0] r_ghr;
    logic [31:0]      r_branch_cnt;
    logic [31:0]      r_mispredict_cnt;

    logic [IDX_W-1:0] w_lk_bidx;
    logic [IDX_W-1:0] w_lk_cidx;
    logic [TAG_W-1:0] w_lk_tag;
    logic             w_lk_hit;
    logic [IDX_W-1:0] w_up_bidx;
    logic [IDX_W-1:0] w_up_cidx;
    logic [TAG_W-1:0] w_up_tag;
    logic [CTR_W-1:0] w_ctr_cur;
    logic [CTR_W-1:0] w_ctr_nxt;
    logic [GHR_W-1:0] w_ghr_nxt;
    logic             w_upd_en;
    logic             w_unused;

    // Lookup side indexes off the live history; the low two pc bits never matter.
    assign w_lk_bidx = if_pc[IDX_W+1:2];
    assign w_lk_tag  = if_pc[IDX_W+1+TAG_W:IDX_W+2];
    assign w_lk_cidx = (MODE == 0) ? w_lk_bidx : (w_lk_bidx ^ IDX_W'(r_ghr));

    // Update side uses the history snapshot that travelled with the branch.
    assign w_up_bidx = upd_pc[IDX_W+1:2];
    assign w_up_tag  = upd_pc[IDX_W+1+TAG_W:IDX_W+2];
    assign w_up_cidx = (MODE == 0) ? w_up_bidx : (w_up_bidx ^ IDX_W'(upd_ghr));

    assign w_unused = ^{if_pc, upd_pc};

    // clr wins over a same-cycle update, which is dropped entirely.
    assign w_upd_en = upd_valid && !clr;

    assign w_lk_hit    = r_btb_valid[w_lk_bidx] && (r_btb_tag[w_lk_bidx] == w_lk_tag);
    assign pred_taken  = w_lk_hit && r_ctr[w_lk_cidx][CTR_W-1];
    assign pred_target = w_lk_hit ? r_btb_tgt[w_lk_bidx] : '0;
    assign pred_ghr    = r_ghr;

    assign branch_cnt     = r_branch_cnt;
    assign mispredict_cnt = r_mispredict_cnt;

    // Saturating counter step for the trained entry.
    always_comb begin
        w_ctr_cur = r_ctr[w_up_cidx];
        w_ctr_nxt = w_ctr_cur;
        if (upd_taken) begin
            if (w_ctr_cur != CTR_MAX) begin
                w_ctr_nxt = w_ctr_cur + CTR_W'(1);
            end
        end else if (w_ctr_cur != '0) begin
            w_ctr_nxt = w_ctr_cur - CTR_W'(1);
        end
    end

    generate
        if (GHR_W == 1) begin : g_ghr_one
            assign w_ghr_nxt = upd_taken;
        end else begin : g_ghr_shift
            assign w_ghr_nxt = {r_ghr[GHR_W-2:0], upd_taken};
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= CTR_RST;
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= CTR_RST;
            end
        end else if (upd_valid) begin
            r_ctr[w_up_cidx] <= w_ctr_nxt;
        end
    end

    // Only taken branches allocate; an alias at the same bidx is simply overwritten.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_btb_valid[i] <= 1'b0;
                r_btb_tag[i]   <= '0;
                r_btb_tgt[i]   <= '0;
            end
        end else if (clr) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_btb_valid[i] <= 1'b0;
            end
        end else if (upd_valid && upd_taken) begin
            r_btb_valid[w_up_bidx] <= 1'b1;
            r_btb_tag[w_up_bidx]   <= w_up_tag;
            r_btb_tgt[w_up_bidx]   <= upd_target;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ghr <= '0;
        end else if (clr) begin
            r_ghr <= '0;
        end else if (upd_valid) begin
            r_ghr <= w_ghr_nxt;
        end
    end

    // Statistics survive clr and saturate rather than wrap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_branch_cnt     <= '0;
            r_mispredict_cnt <= '0;
        end else if (w_upd_en) begin
            if (r_branch_cnt != CNT_MAX) begin
                r_branch_cnt <= r_branch_cnt + 32'd1;
            end
            if (upd_mispredict && (r_mispredict_cnt != CNT_MAX)) begin
                r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Bench for branch_predictor: bimodal and gshare instances share stimulus and are
// compared every cycle against a table-level reference model.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic [31:0] if_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic [5:0]  upd_ghr;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;

    logic        pt0, pt1;
    logic [31:0] ptg0, ptg1;
    logic [5:0]  pg0, pg1;
    logic [31:0] bc0, bc1, mc0, mc1;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: one counter table per indexing mode, one BTB, shared history.
    int unsigned m_ctr [2][64];
    bit          m_val [64];
    int unsigned m_tag [64];
    logic [31:0] m_tgt [64];
    int unsigned m_ghr;
    longint      m_bc;
    longint      m_mc;

    always #5 clk = ~clk;

    branch_predictor #(.MODE(0)) u_bim (
        .clk(clk), .rst(rst), .clr(clr), .if_pc(if_pc),
        .pred_taken(pt0), .pred_target(ptg0), .pred_ghr(pg0),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .branch_cnt(bc0), .mispredict_cnt(mc0)
    );

    branch_predictor #(.MODE(1)) u_gsh (
        .clk(clk), .rst(rst), .clr(clr), .if_pc(if_pc),
        .pred_taken(pt1), .pred_target(ptg1), .pred_ghr(pg1),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
        .upd_taken(upd_taken), .upd_target(upd_target), .upd_mispredict(upd_mispredict),
        .branch_cnt(bc1), .mispredict_cnt(mc1)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int unsigned f_bidx(input logic [31:0] pc);
        return (pc / 4) % 64;
    endfunction

    function automatic int unsigned f_tag(input logic [31:0] pc);
        return (pc / 256) % 256;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) begin
            m_ctr[0][i] = 1;
            m_ctr[1][i] = 1;
            m_val[i]    = 1'b0;
            m_tag[i]    = 0;
            m_tgt[i]    = '0;
        end
        m_ghr = 0;
        m_bc  = 0;
        m_mc  = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        int unsigned b;
        int unsigned c;
        if (clr) begin
            for (int i = 0; i < 64; i++) begin
                m_ctr[0][i] = 1;
                m_ctr[1][i] = 1;
                m_val[i]    = 1'b0;
            end
            m_ghr = 0;
        end else if (upd_valid) begin
            b = f_bidx(upd_pc);
            for (int m = 0; m < 2; m++) begin
                c = (m == 0) ? b : (b ^ int'(upd_ghr));
                if (upd_taken) m_ctr[m][c] = (m_ctr[m][c] < 3) ? m_ctr[m][c] + 1 : 3;
                else           m_ctr[m][c] = (m_ctr[m][c] > 0) ? m_ctr[m][c] - 1 : 0;
            end
            if (upd_taken) begin
                m_val[b] = 1'b1;
                m_tag[b] = f_tag(upd_pc);
                m_tgt[b] = upd_target;
            end
            m_ghr = (m_ghr * 2 + int'(upd_taken)) % 64;
            if (m_bc < 64'hFFFF_FFFF) m_bc++;
            if (upd_mispredict && m_mc < 64'hFFFF_FFFF) m_mc++;
        end
    endtask

    task automatic compare();
        int unsigned b;
        int unsigned c1;
        bit          hit;
        bit          e0;
        bit          e1;
        logic [31:0] et;
        b   = f_bidx(if_pc);
        hit = m_val[b] && (m_tag[b] == f_tag(if_pc));
        c1  = b ^ m_ghr;
        e0  = hit && (m_ctr[0][b] >= 2);
        e1  = hit && (m_ctr[1][c1] >= 2);
        et  = hit ? m_tgt[b] : 32'h0;
        check("bim_taken",  pt0,  e0);
        check("bim_target", ptg0, et);
        check("bim_ghr",    pg0,  m_ghr);
        check("bim_bcnt",   bc0,  m_bc);
        check("bim_mcnt",   mc0,  m_mc);
        check("gsh_taken",  pt1,  e1);
        check("gsh_target", ptg1, et);
        check("gsh_ghr",    pg1,  m_ghr);
        check("gsh_bcnt",   bc1,  m_bc);
        check("gsh_mcnt",   mc1,  m_mc);
    endtask

    task automatic cycle(input bit c, input bit uv, input logic [31:0] upc, input logic [5:0] ughr,
                         input bit utk, input logic [31:0] utgt, input bit umis,
                         input logic [31:0] lpc);
        @(negedge clk);
        clr            = c;
        upd_valid      = uv;
        upd_pc         = upc;
        upd_ghr        = ughr;
        upd_taken      = utk;
        upd_target     = utgt;
        upd_mispredict = umis;
        if_pc          = lpc;
        #1;
        compare();
        model_step();
    endtask

    task automatic upd(input logic [31:0] pc, input logic [5:0] g, input bit tk,
                       input logic [31:0] tgt, input bit mis);
        cycle(1'b0, 1'b1, pc, g, tk, tgt, mis, pc);
    endtask

    task automatic look(input logic [31:0] pc);
        cycle(1'b0, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, pc);
    endtask

    task automatic clear();
        cycle(1'b1, 1'b0, 32'h0, 6'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    function automatic logic [31:0] rand_pc();
        return 32'(($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 2) | $urandom_range(0, 3));
    endfunction

    initial begin
        longint saved_bc;
        rst = 1'b1; clr = 1'b0; if_pc = 32'h40;
        upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0;
        upd_target = '0; upd_mispredict = 1'b0;
        model_reset();
        #3;
        compare();
        check("rst_taken", pt0, 1'b0);
        check("rst_target", ptg0, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Two taken updates make the bimodal entry predict taken.
        upd(32'h40, 6'h0, 1'b1, 32'h100, 1'b0);
        upd(32'h40, 6'h0, 1'b1, 32'h100, 1'b0);
        look(32'h40);
        check("basic_taken", pt0, 1'b1);
        check("basic_target", ptg0, 32'h100);
        check("basic_bcnt", bc0, 32'd2);

        // Saturation: strong taken survives one not-taken, not two.
        clear();
        repeat (5) upd(32'h40, 6'h0, 1'b1, 32'h100, 1'b0);
        upd(32'h40, 6'h0, 1'b0, 32'h0, 1'b0);
        look(32'h40);
        check("sat_one_nt", pt0, 1'b1);
        upd(32'h40, 6'h0, 1'b0, 32'h0, 1'b0);
        look(32'h40);
        check("sat_two_nt", pt0, 1'b0);
        check("sat_hit_target", ptg0, 32'h100);

        // Alias at the same bidx with a different tag.
        clear();
        upd(32'h40, 6'h0, 1'b1, 32'h100, 1'b0);
        upd(32'h40, 6'h0, 1'b1, 32'h100, 1'b0);
        look(32'h140);
        check("alias_miss_taken", pt0, 1'b0);
        check("alias_miss_target", ptg0, 32'h0);
        upd(32'h140, 6'h0, 1'b1, 32'h200, 1'b0);
        look(32'h40);
        check("alias_evict_taken", pt0, 1'b0);
        check("alias_evict_target", ptg0, 32'h0);
        look(32'h140);
        check("alias_new_target", ptg0, 32'h200);

        // Gshare: entry trained under history 1 only predicts taken under history 1.
        clear();
        upd(32'h40, 6'h01, 1'b1, 32'h100, 1'b0);
        upd(32'h40, 6'h01, 1'b1, 32'h100, 1'b0);
        check("ghr_shift", pg1, 6'h01);
        repeat (6) upd(32'h80, 6'h0, 1'b0, 32'h0, 1'b0);
        look(32'h40);
        check("gsh_ghr0", pg1, 6'h00);
        check("gsh_ghr0_taken", pt1, 1'b0);
        check("gsh_ghr0_target", ptg1, 32'h100);
        upd(32'h84, 6'h0, 1'b1, 32'h300, 1'b0);
        look(32'h40);
        check("gsh_ghr1", pg1, 6'h01);
        check("gsh_ghr1_taken", pt1, 1'b1);

        // Same-cycle lookup sees the pre-update counter.
        clear();
        upd(32'h40, 6'h0, 1'b1, 32'h100, 1'b0);
        upd(32'h40, 6'h0, 1'b0, 32'h0, 1'b0);
        cycle(1'b0, 1'b1, 32'h40, 6'h0, 1'b1, 32'h100, 1'b0, 32'h40);
        check("bypass_same", pt0, 1'b0);
        look(32'h40);
        check("bypass_next", pt0, 1'b1);

        // clr beats a same-cycle update; statistics are kept.
        saved_bc = m_bc;
        cycle(1'b1, 1'b1, 32'h40, 6'h0, 1'b1, 32'h100, 1'b1, 32'h40);
        look(32'h40);
        check("clr_taken", pt0, 1'b0);
        check("clr_target", ptg0, 32'h0);
        check("clr_ghr", pg0, 6'h0);
        check("clr_bcnt_kept", bc0, saved_bc);

        // Asynchronous reset mid-training.
        upd(32'h40, 6'h0, 1'b1, 32'h100, 1'b1);
        upd(32'h40, 6'h0, 1'b1, 32'h100, 1'b0);
        @(negedge clk);
        upd_valid = 1'b0;
        clr = 1'b0;
        if_pc = 32'h40;
        #2 rst = 1'b1;
        #1;
        model_reset();
        compare();
        check("rstmid_taken", pt0, 1'b0);
        check("rstmid_bcnt", bc0, 32'd0);
        check("rstmid_mcnt", mc0, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // One mispredict among three resolved branches.
        upd(32'h40, 6'h0, 1'b1, 32'h100, 1'b0);
        upd(32'h44, 6'h0, 1'b0, 32'h0, 1'b1);
        upd(32'h4B, 6'h0, 1'b1, 32'h104, 1'b0);
        look(32'h48);
        check("misp_mcnt", mc0, 32'd1);
        check("misp_bcnt", bc0, 32'd3);
        check("misp_unaligned_target", ptg0, 32'h104);

        // Randomized traffic over a small pc pool so entries hit, alias and saturate.
        repeat (3000) begin
            logic [5:0] g;
            g = ($urandom_range(0, 1) == 0) ? 6'(m_ghr) : 6'($urandom_range(0, 63));
            cycle(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)), rand_pc(), g,
                  1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), rand_pc());
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
